// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: load-use and branch control in RUN, plus interrupt entry (drain, push PC hi/lo, vector).
// Hazard outputs are combinational from registered state; pushes wait indefinitely on mem_ack.
module pipeline_ctrl #(
  parameter int REG_W        = 3,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_branch_taken,
  input  logic             int_req,
  input  logic [31:0]      pc_current,
  input  logic             mem_ack,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             mem_push_req,
  output logic [15:0]      mem_push_data,
  output logic             int_ack,
  output logic             busy
);

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    DRAIN   = 3'd1,
    PUSH_HI = 3'd2,
    PUSH_LO = 3'd3,
    VEC     = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

  state_t      state;
  logic [2:0]  drain_cnt;
  logic [31:0] saved_pc;
  logic        int_pending;
  logic        load_use;
  logic        accept;

  assign load_use = ex_mem_read &
                    ((id_uses_rs & (ex_rd == id_rs)) | (id_uses_rt & (ex_rd == id_rt)));
  assign accept   = (state == RUN) & int_pending & ~ex_branch_taken & ~load_use;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      drain_cnt   <= 3'd0;
      saved_pc    <= 32'd0;
      int_pending <= 1'b0;
    end else begin
      // A request seen on the VEC-entry edge survives the clear, so held levels re-enter.
      int_pending <= int_req | (int_pending & ~((state == PUSH_LO) & mem_ack));
      case (state)
        RUN: begin
          if (accept) begin
            saved_pc  <= pc_current;
            drain_cnt <= DRAIN_INIT;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) state <= PUSH_HI;
          else                   drain_cnt <= drain_cnt - 3'd1;
        end
        PUSH_HI: if (mem_ack) state <= PUSH_LO;
        PUSH_LO: if (mem_ack) state <= VEC;
        VEC:     state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    stall_if_id   = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    pc_write      = 1'b1;
    pc_sel        = 2'd0;
    mem_push_req  = 1'b0;
    mem_push_data = 16'd0;
    int_ack       = 1'b0;
    busy          = 1'b0;
    // Outputs are forced to their idle values while reset is held, regardless of inputs.
    if (reset) begin
      case (state)
        RUN: begin
          if (ex_branch_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            pc_sel      = 2'd1;
          end else if (load_use) begin
            stall_if_id = 1'b1;
            pc_write    = 1'b0;
            flush_id_ex = 1'b1;
          end
        end
        DRAIN: begin
          busy        = 1'b1;
          pc_write    = 1'b0;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
        end
        PUSH_HI, PUSH_LO: begin
          busy          = 1'b1;
          pc_write      = 1'b0;
          flush_if_id   = 1'b1;
          mem_push_req  = 1'b1;
          mem_push_data = (state == PUSH_HI) ? saved_pc[31:16] : saved_pc[15:0];
        end
        VEC: begin
          busy        = 1'b1;
          flush_if_id = 1'b1;
          pc_sel      = 2'd2;
          int_ack     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, interrupt entry, deferral, ack stall, reset mid-push.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, ex_mem_read, ex_branch_taken, int_req, mem_ack;
  logic [31:0] pc_current;
  logic        stall_if_id, flush_if_id, flush_id_ex, pc_write, mem_push_req, int_ack, busy;
  logic [1:0]  pc_sel;
  logic [15:0] mem_push_data;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(.REG_W(3), .DRAIN_CYCLES(3)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
    .int_req(int_req), .pc_current(pc_current), .mem_ack(mem_ack),
    .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .pc_write(pc_write), .pc_sel(pc_sel), .mem_push_req(mem_push_req),
    .mem_push_data(mem_push_data), .int_ack(int_ack), .busy(busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk1({tag, "_stall"}, stall_if_id, 1'b0);
    chk1({tag, "_flush_ifid"}, flush_if_id, 1'b0);
    chk1({tag, "_flush_idex"}, flush_id_ex, 1'b0);
    chk1({tag, "_pc_write"}, pc_write, 1'b1);
    chkw({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
    chk1({tag, "_push_req"}, mem_push_req, 1'b0);
    chkw({tag, "_push_data"}, 32'(mem_push_data), 32'd0);
    chk1({tag, "_int_ack"}, int_ack, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; int_req = 1'b0; mem_ack = 1'b0;
    pc_current = 32'd0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    // Hazard inputs active during reset must not leak through.
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    #2;
    chk_idle_outputs("reset");
    clear_inputs();
    tick();
    reset = 1'b1;
    #1;
    chk_idle_outputs("run_idle");
    tick();

    // Load-use on rs: exactly one bubble.
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b1;
    #1;
    chk1("lu_stall", stall_if_id, 1'b1);
    chk1("lu_pc_write", pc_write, 1'b0);
    chk1("lu_flush_idex", flush_id_ex, 1'b1);
    chk1("lu_flush_ifid", flush_if_id, 1'b0);
    tick();
    clear_inputs();
    #1;
    chk1("lu_after_stall", stall_if_id, 1'b0);
    chk1("lu_after_pc_write", pc_write, 1'b1);
    tick();

    // Same registers but rs unused: no hazard.
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_uses_rs = 1'b0;
    #1;
    chk1("nouse_stall", stall_if_id, 1'b0);
    chk1("nouse_pc_write", pc_write, 1'b1);
    tick();

    // Load-use via rt.
    clear_inputs();
    ex_mem_read = 1'b1; ex_rd = 3'd5; id_rt = 3'd5; id_uses_rt = 1'b1; id_rs = 3'd2; id_uses_rs = 1'b1;
    #1;
    chk1("lu_rt_stall", stall_if_id, 1'b1);
    tick();

    // Branch beats load-use.
    ex_branch_taken = 1'b1;
    #1;
    chk1("br_lu_flush_ifid", flush_if_id, 1'b1);
    chk1("br_lu_flush_idex", flush_id_ex, 1'b1);
    chkw("br_lu_pc_sel", 32'(pc_sel), 32'd1);
    chk1("br_lu_stall", stall_if_id, 1'b0);
    chk1("br_lu_pc_write", pc_write, 1'b1);
    tick();
    clear_inputs();

    // Interrupt entry with ack one cycle after each request.
    int_req = 1'b1; pc_current = 32'h0001_2345;
    #1;
    chk1("int_req_cycle_busy", busy, 1'b0);
    tick();
    int_req = 1'b0;
    #1;
    chk1("int_pending_cycle_busy", busy, 1'b0);
    tick();
    busy_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      mem_ack = (c == 4 || c == 6);
      #1;
      if (busy) busy_cnt++;
      chk1($sformatf("int_c%0d_req", c), mem_push_req, (c >= 3 && c <= 6));
      chkw($sformatf("int_c%0d_data", c), 32'(mem_push_data),
           (c == 3 || c == 4) ? 32'h0001 : (c == 5 || c == 6) ? 32'h2345 : 32'h0);
      chk1($sformatf("int_c%0d_ack", c), int_ack, (c == 7));
      chkw($sformatf("int_c%0d_pc_sel", c), 32'(pc_sel), (c == 7) ? 32'd2 : 32'd0);
      chk1($sformatf("int_c%0d_pc_write", c), pc_write, (c >= 7));
      chk1($sformatf("int_c%0d_flush_idex", c), flush_id_ex, (c <= 2));
      chk1($sformatf("int_c%0d_flush_ifid", c), flush_if_id, (c <= 7));
      tick();
    end
    mem_ack = 1'b0;
    chkw("int_busy_cycles", 32'(busy_cnt), 32'd8);

    // Interrupt during taken branches: deferred, then saves post-branch PC.
    ex_branch_taken = 1'b1; int_req = 1'b1; pc_current = 32'h0000_1111;
    #1;
    chk1("defer_c0_busy", busy, 1'b0);
    chk1("defer_c0_flush", flush_if_id, 1'b1);
    tick();
    int_req = 1'b0; pc_current = 32'h0000_2222;
    #1;
    chk1("defer_c1_busy", busy, 1'b0);
    tick();
    ex_branch_taken = 1'b0; pc_current = 32'hABCD_0042;
    #1;
    chk1("defer_c2_busy", busy, 1'b0);
    chk1("defer_c2_pc_write", pc_write, 1'b1);
    tick();
    pc_current = 32'h0;
    for (int c = 0; c < 3; c++) begin
      ex_branch_taken = (c == 1);
      #1;
      chk1($sformatf("defer_drain%0d_busy", c), busy, 1'b1);
      chk1($sformatf("defer_drain%0d_pc_write", c), pc_write, 1'b0);
      chkw($sformatf("defer_drain%0d_pc_sel", c), 32'(pc_sel), 32'd0);
      chk1($sformatf("defer_drain%0d_req", c), mem_push_req, 1'b0);
      tick();
    end
    ex_branch_taken = 1'b0;

    // Ack withheld for 10 cycles in PUSH_HI.
    for (int c = 0; c < 10; c++) begin
      #1;
      chk1($sformatf("hold%0d_req", c), mem_push_req, 1'b1);
      chkw($sformatf("hold%0d_data", c), 32'(mem_push_data), 32'hABCD);
      chk1($sformatf("hold%0d_pc_write", c), pc_write, 1'b0);
      tick();
    end
    mem_ack = 1'b1;
    #1;
    chkw("hold_ack_data", 32'(mem_push_data), 32'hABCD);
    tick();
    mem_ack = 1'b0;
    #1;
    chk1("pushlo_req", mem_push_req, 1'b1);
    chkw("pushlo_data", 32'(mem_push_data), 32'h0042);

    // Asynchronous reset in the middle of PUSH_LO.
    #2;
    reset = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    tick();
    reset = 1'b1;
    #1;
    chk1("post_rst_c0_busy", busy, 1'b0);
    tick();
    #1;
    chk1("post_rst_c1_busy", busy, 1'b0);
    tick();
    #1;
    chk1("post_rst_c2_busy", busy, 1'b0);
    chk1("post_rst_c2_pc_write", pc_write, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
